// File: rtl/magic_counter_monitor.sv
// rtl/magic_counter_monitor.sv - runtime monitor for a free-running up-counter
// Flags out-of-order steps, illegal wraps, oversized steps and skipped magic values.
module magic_counter_monitor #(
  parameter int                          WIDTH       = 20,
  parameter int                          NUM_MAGIC   = 4,
  parameter logic [NUM_MAGIC*WIDTH-1:0]  MAGICS      = {20'd456789, 20'd345678, 20'd234567, 20'd123456},
  parameter int unsigned                 MAX_STEP    = 0,
  parameter bit                          HALT_ON_ERR = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  counter_valid,
  input  logic [WIDTH-1:0]      counter,
  output logic                  err_order,
  output logic                  err_skip,
  output logic                  err_step,
  output logic                  err_any,
  output logic [WIDTH-1:0]      first_err_value,
  output logic [3:0]            first_skip_idx,
  output logic [NUM_MAGIC-1:0]  magic_hit,
  output logic [7:0]            wrap_count,
  output logic                  halted
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("magic_counter_monitor: WIDTH must be in 2..32");
  end
  if (NUM_MAGIC < 1 || NUM_MAGIC > 16) begin : g_bad_num
    $error("magic_counter_monitor: NUM_MAGIC must be in 1..16");
  end
  for (genvar g = 0; g < NUM_MAGIC - 1; g++) begin : g_order
    if (MAGICS[(g+1)*WIDTH +: WIDTH] <= MAGICS[g*WIDTH +: WIDTH]) begin : g_bad
      $error("magic_counter_monitor: MAGICS must be strictly ascending");
    end
  end

  typedef enum logic [1:0] {IDLE, TRACK, HALT} state_t;

  state_t                state, state_next;
  logic [WIDTH-1:0]      prev;
  logic [NUM_MAGIC-1:0]  hit_vec, skip_vec;
  logic [3:0]            skip_idx;
  logic [WIDTH-1:0]      diff;
  logic                  prev_is_max, gt, order_bad, step_bad, skip_any, wrap, err_now;

  // Checks are evaluated every cycle; they only take effect for a valid sample in TRACK.
  always_comb begin
    hit_vec     = '0;
    skip_vec    = '0;
    skip_idx    = 4'd0;
    prev_is_max = (prev == {WIDTH{1'b1}});
    gt          = (counter > prev);
    diff        = counter - prev;
    order_bad   = prev_is_max ? (counter != '0) : !gt;
    wrap        = prev_is_max && (counter == '0);
    step_bad    = (MAX_STEP != 0) && !prev_is_max && !order_bad && (33'(diff) > 33'(MAX_STEP));
    for (int i = 0; i < NUM_MAGIC; i++) begin
      hit_vec[i]  = (counter == MAGICS[i*WIDTH +: WIDTH]);
      skip_vec[i] = gt && (prev < MAGICS[i*WIDTH +: WIDTH]) && (counter > MAGICS[i*WIDTH +: WIDTH]);
    end
    for (int i = NUM_MAGIC - 1; i >= 0; i--) begin
      if (skip_vec[i]) skip_idx = 4'(i);
    end
    skip_any = |skip_vec;
    err_now  = order_bad || step_bad || skip_any;
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (counter_valid) state_next = TRACK;
        TRACK:   if (counter_valid && err_now && HALT_ON_ERR) state_next = HALT;
        HALT:    state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      prev            <= '0;
      err_order       <= 1'b0;
      err_skip        <= 1'b0;
      err_step        <= 1'b0;
      err_any         <= 1'b0;
      first_err_value <= '0;
      first_skip_idx  <= 4'd0;
      magic_hit       <= '0;
      wrap_count      <= 8'd0;
    end else if (counter_valid) begin
      case (state)
        IDLE: begin
          prev      <= counter;
          magic_hit <= magic_hit | hit_vec;
        end
        TRACK: begin
          prev      <= counter;
          magic_hit <= magic_hit | hit_vec;
          err_order <= err_order | order_bad;
          err_step  <= err_step | step_bad;
          err_skip  <= err_skip | skip_any;
          err_any   <= err_any | err_now;
          if (err_now && !err_any) first_err_value <= counter;
          if (skip_any && !err_skip) first_skip_idx <= skip_idx;
          if (wrap && wrap_count != 8'hFF) wrap_count <= wrap_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign halted = (state == HALT);

endmodule
